// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: FETCH/EXEC/MEM/HALT sequencer with an external synchronous ROM
// and a RAM port that uses a ready handshake.
module acc_cpu_core #(
  parameter int unsigned NB_INSTRUCTION = 16,
  parameter int unsigned NB_OPCODE      = 5,
  parameter int unsigned NB_OPERAND     = NB_INSTRUCTION - NB_OPCODE,
  parameter int unsigned NB_ADDR        = 11
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [NB_INSTRUCTION-1:0] i_rom_data,
  input  logic [NB_INSTRUCTION-1:0] i_ram_data,
  input  logic                      i_ram_ready,
  output logic [NB_ADDR-1:0]        o_rom_addr,
  output logic [NB_ADDR-1:0]        o_ram_addr,
  output logic [NB_INSTRUCTION-1:0] o_ram_data,
  output logic                      o_ram_wr_enable,
  output logic                      o_ram_rd_enable,
  output logic [NB_INSTRUCTION-1:0] o_acc,
  output logic                      o_halted
);

  localparam int unsigned NB_SH = $clog2(NB_INSTRUCTION);

  localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(5'h00);
  localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(5'h01);
  localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(5'h02);
  localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(5'h03);
  localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(5'h04);
  localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5'h05);
  localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(5'h06);
  localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(5'h07);
  localparam logic [NB_OPCODE-1:0] OP_AND  = NB_OPCODE'(5'h08);
  localparam logic [NB_OPCODE-1:0] OP_ANDI = NB_OPCODE'(5'h09);
  localparam logic [NB_OPCODE-1:0] OP_OR   = NB_OPCODE'(5'h0A);
  localparam logic [NB_OPCODE-1:0] OP_ORI  = NB_OPCODE'(5'h0B);
  localparam logic [NB_OPCODE-1:0] OP_XOR  = NB_OPCODE'(5'h0C);
  localparam logic [NB_OPCODE-1:0] OP_XORI = NB_OPCODE'(5'h0D);
  localparam logic [NB_OPCODE-1:0] OP_SLL  = NB_OPCODE'(5'h0E);
  localparam logic [NB_OPCODE-1:0] OP_SRA  = NB_OPCODE'(5'h0F);
  localparam logic [NB_OPCODE-1:0] OP_BEQ  = NB_OPCODE'(5'h10);
  localparam logic [NB_OPCODE-1:0] OP_BNE  = NB_OPCODE'(5'h11);
  localparam logic [NB_OPCODE-1:0] OP_JMP  = NB_OPCODE'(5'h12);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t                      r_state;
  logic [NB_ADDR-1:0]          r_pc;
  logic [NB_INSTRUCTION-1:0]   r_acc;
  logic [NB_INSTRUCTION-1:0]   r_ir;
  logic                        r_ram_wr;
  logic                        r_ram_rd;
  logic                        r_halted;

  logic [NB_OPCODE-1:0]        w_op;
  logic [NB_OPERAND-1:0]       w_opd;
  logic [NB_INSTRUCTION-1:0]   w_imm;
  logic [NB_SH-1:0]            w_sh;
  logic [NB_ADDR-1:0]          w_target;
  logic [NB_ADDR-1:0]          w_pc_inc;
  logic                        w_is_mem;
  logic [NB_OPCODE-1:0]        w_ir_op;
  logic [NB_INSTRUCTION-1:0]   w_exec_acc;
  logic [NB_ADDR-1:0]          w_exec_pc;
  logic [NB_INSTRUCTION-1:0]   w_mem_acc;

  assign w_op     = i_rom_data[NB_INSTRUCTION-1 -: NB_OPCODE];
  assign w_opd    = i_rom_data[NB_OPERAND-1:0];
  assign w_imm    = NB_INSTRUCTION'($signed(w_opd));
  assign w_sh     = w_opd[NB_SH-1:0];
  assign w_target = w_opd[NB_ADDR-1:0];
  assign w_pc_inc = r_pc + NB_ADDR'(1);
  assign w_ir_op  = r_ir[NB_INSTRUCTION-1 -: NB_OPCODE];

  assign w_is_mem = (w_op == OP_STO) || (w_op == OP_LD)  || (w_op == OP_ADD) ||
                    (w_op == OP_SUB) || (w_op == OP_AND) || (w_op == OP_OR)  ||
                    (w_op == OP_XOR);

  // Single-cycle (immediate, shift, branch) results applied at the end of EXEC
  always_comb begin
    w_exec_acc = r_acc;
    w_exec_pc  = w_pc_inc;
    case (w_op)
      OP_HLT:  w_exec_pc  = r_pc;
      OP_LDI:  w_exec_acc = w_imm;
      OP_ADDI: w_exec_acc = r_acc + w_imm;
      OP_SUBI: w_exec_acc = r_acc - w_imm;
      OP_ANDI: w_exec_acc = r_acc & w_imm;
      OP_ORI:  w_exec_acc = r_acc | w_imm;
      OP_XORI: w_exec_acc = r_acc ^ w_imm;
      OP_SLL:  w_exec_acc = r_acc << w_sh;
      OP_SRA:  w_exec_acc = NB_INSTRUCTION'($signed(r_acc) >>> w_sh);
      OP_BEQ:  w_exec_pc  = (r_acc == '0) ? w_target : w_pc_inc;
      OP_BNE:  w_exec_pc  = (r_acc != '0) ? w_target : w_pc_inc;
      OP_JMP:  w_exec_pc  = w_target;
      default: ;
    endcase
  end

  // Result of a RAM-operand instruction, applied when the access completes
  always_comb begin
    w_mem_acc = r_acc;
    case (w_ir_op)
      OP_LD:   w_mem_acc = i_ram_data;
      OP_ADD:  w_mem_acc = r_acc + i_ram_data;
      OP_SUB:  w_mem_acc = r_acc - i_ram_data;
      OP_AND:  w_mem_acc = r_acc & i_ram_data;
      OP_OR:   w_mem_acc = r_acc | i_ram_data;
      OP_XOR:  w_mem_acc = r_acc ^ i_ram_data;
      default: ;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= ST_FETCH;
      r_pc     <= '0;
      r_acc    <= '0;
      r_ir     <= '0;
      r_ram_wr <= 1'b0;
      r_ram_rd <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: r_state <= ST_EXEC;
        ST_EXEC: begin
          r_ir <= i_rom_data;
          if (w_op == OP_HLT) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else if (w_is_mem) begin
            r_ram_wr <= (w_op == OP_STO);
            r_ram_rd <= (w_op != OP_STO);
            r_state  <= ST_MEM;
          end else begin
            r_acc   <= w_exec_acc;
            r_pc    <= w_exec_pc;
            r_state <= ST_FETCH;
          end
        end
        ST_MEM: begin
          if (i_ram_ready) begin
            r_acc    <= w_mem_acc;
            r_pc     <= w_pc_inc;
            r_ram_wr <= 1'b0;
            r_ram_rd <= 1'b0;
            r_state  <= ST_FETCH;
          end
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  assign o_rom_addr      = r_pc;
  assign o_ram_addr      = r_ir[NB_ADDR-1:0];
  assign o_ram_data      = r_acc;
  assign o_ram_wr_enable = r_ram_wr;
  assign o_ram_rd_enable = r_ram_rd;
  assign o_acc           = r_acc;
  assign o_halted        = r_halted;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Scoreboard bench for acc_cpu_core: an instruction-level reference model predicts RAM
// transactions and the halt state; a monitor compares them as the core produces them.
module tb_acc_cpu_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] rom_data = '0;
  logic [15:0] ram_data;
  logic        ready = 1'b0;
  logic [10:0] rom_addr, ram_addr;
  logic [15:0] ram_wdata, acc;
  logic        wr_en, rd_en, halted;

  always #5 clk = ~clk;

  acc_cpu_core dut (
    .i_clock(clk), .i_reset(rst_n), .i_rom_data(rom_data), .i_ram_data(ram_data),
    .i_ram_ready(ready), .o_rom_addr(rom_addr), .o_ram_addr(ram_addr),
    .o_ram_data(ram_wdata), .o_ram_wr_enable(wr_en), .o_ram_rd_enable(rd_en),
    .o_acc(acc), .o_halted(halted)
  );

  typedef struct {
    int kind;   // 0 read, 1 write, 2 halt
    int addr;
    int data;
    int hold;
    int pc;
    int acc;
    int cyc;
  } ev_t;

  logic [15:0] rom  [0:2047];
  logic [15:0] ram  [0:2047];
  logic [15:0] mram [0:2047];
  ev_t exp_q[$];
  int  waits_q[$];
  int  n_checks = 0, n_pass = 0;
  int  cyc = 0, hold = 0, both_cnt = 0;
  bit  halted_seen = 0;
  int  m_acc, m_pc;

  assign ram_data = ram[ram_addr];

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, got, exp, $time);
  endtask

  function automatic logic [15:0] ins(input int op, input int opd);
    return 16'((op << 11) | (opd & 2047));
  endfunction

  // Instruction-level reference: executes the ROM image and records expected events
  task automatic model_run(input int wmin, input int wmax);
    int pc, a, c, op, opd, imm, sh, w, m, sv;
    logic [15:0] iw;
    bit mem;
    pc = 0; a = 0; c = 0;
    for (int i = 0; i < 2048; i++) mram[i] = ram[i];
    for (int step = 0; step < 4000; step++) begin
      iw  = rom[pc];
      op  = int'(iw[15:11]);
      opd = int'(iw[10:0]);
      imm = (opd >= 1024) ? opd - 2048 : opd;
      sh  = opd % 16;
      if (op == 0) begin
        c += 2;
        m_acc = a; m_pc = pc;
        exp_q.push_back('{kind: 2, addr: 0, data: 0, hold: 0, pc: pc, acc: a, cyc: c});
        return;
      end
      mem = (op == 1 || op == 2 || op == 4 || op == 6 || op == 8 || op == 10 || op == 12);
      if (mem) begin
        w = $urandom_range(wmax, wmin);
        waits_q.push_back(w);
        c += 3 + w;
        m = int'(mram[opd]);
        exp_q.push_back('{kind: (op == 1) ? 1 : 0, addr: opd, data: a, hold: w + 1,
                          pc: 0, acc: 0, cyc: 0});
        case (op)
          1:  mram[opd] = 16'(a);
          2:  a = m;
          4:  a = a + m;
          6:  a = a - m;
          8:  a = a & m;
          10: a = a | m;
          default: a = a ^ m;
        endcase
        pc = (pc + 1) % 2048;
      end else begin
        c += 2;
        case (op)
          3:  a = imm;
          5:  a = a + imm;
          7:  a = a - imm;
          9:  a = a & (imm & 65535);
          11: a = a | (imm & 65535);
          13: a = a ^ (imm & 65535);
          14: a = a << sh;
          15: begin sv = (a >= 32768) ? a - 65536 : a; a = sv >>> sh; end
          default: ;
        endcase
        if      (op == 16) pc = (a == 0) ? opd : (pc + 1) % 2048;
        else if (op == 17) pc = (a != 0) ? opd : (pc + 1) % 2048;
        else if (op == 18) pc = opd;
        else               pc = (pc + 1) % 2048;
      end
      a = a & 65535;
    end
  endtask

  // Cycle counter since reset release
  initial forever begin
    @(posedge clk);
    if (!rst_n) cyc = 0; else cyc++;
  end

  // RAM ready driver: per-access wait counts come from the model; random ready elsewhere
  initial begin
    int  wl;
    bit  in_acc;
    wl = 0; in_acc = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        in_acc = 0; ready = 1'b0;
      end else if (wr_en || rd_en) begin
        if (!in_acc) begin
          in_acc = 1;
          wl = (waits_q.size() > 0) ? waits_q.pop_front() : 0;
        end
        if (wl == 0) ready = 1'b1;
        else begin ready = 1'b0; wl--; end
      end else begin
        in_acc = 0;
        ready = 1'($urandom_range(1, 0));
      end
    end
  end

  // Monitor: pops the scoreboard whenever the core completes an access or halts
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 0;
      end else begin
        if (wr_en && rd_en) both_cnt++;
        if (wr_en || rd_en) hold++;
        if ((wr_en || rd_en) && ready) begin
          if (exp_q.size() == 0) chk("unexpected_access", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("access_kind", wr_en ? 1 : 0, e.kind);
            chk("access_addr", int'(ram_addr), e.addr);
            chk("enable_hold", hold, e.hold);
            if (wr_en) begin
              chk("write_data", int'(ram_wdata), e.data);
              ram[ram_addr] = ram_wdata;
            end
          end
          hold = 0;
        end
        if (halted && !halted_seen) begin
          halted_seen = 1;
          if (exp_q.size() == 0) chk("unexpected_halt", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("halt_kind", 2, e.kind);
            chk("halt_acc", int'(acc), e.acc);
            chk("halt_pc", int'(rom_addr), e.pc);
            chk("halt_cycles", cyc, e.cyc);
          end
          chk("both_enables", both_cnt, 0);
        end
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) begin
      rom[i] = '0;
      ram[i] = 16'($urandom);
    end
  endtask

  task automatic start_prog(input int wmin, input int wmax);
    halted_seen = 0;
    both_cnt = 0;
    exp_q.delete();
    model_run(wmin, wmax);
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic finish_prog(input string nm);
    int bad;
    for (int i = 0; i < 3000 && !halted_seen; i++) @(negedge clk);
    if (!halted_seen) begin
      $display("FAIL halt_timeout in %s: halted=%0d expected 1", nm, halted);
      n_checks++;
    end
    repeat (3) @(negedge clk);
    chk("frozen_pc", int'(rom_addr), m_pc);
    chk("frozen_acc", int'(acc), m_acc);
    chk("halt_no_req", int'(wr_en | rd_en), 0);
    bad = 0;
    for (int i = 0; i < 2048; i++) if (ram[i] !== mram[i]) bad++;
    chk("ram_image", bad, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    @(posedge clk); #1 rst_n = 1'b0;
  endtask

  initial begin
    int n, op, opd;
    #2;
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_ram_addr", int'(ram_addr), 0);
    chk("rst_ram_data", int'(ram_wdata), 0);
    chk("rst_enables", int'({wr_en, rd_en}), 0);
    chk("rst_acc", int'(acc), 0);
    chk("rst_halted", int'(halted), 0);

    // Small program: LDI 5, ADDI -3, STO 7, HLT
    clear_mem();
    rom[0] = ins(3, 5); rom[1] = ins(5, -3); rom[2] = ins(1, 7); rom[3] = ins(0, 0);
    start_prog(0, 0);
    finish_prog("basic");
    chk("ram7_is_2", int'(ram[7]), 2);

    // LD with three wait cycles
    clear_mem();
    ram[4] = 16'h1234;
    rom[0] = ins(2, 4); rom[1] = ins(0, 0);
    start_prog(3, 3);
    finish_prog("ld_wait");

    // Branch taken/not-taken chain
    clear_mem();
    rom[0] = ins(3, 0); rom[1] = ins(16, 'h20);
    rom['h20] = ins(3, 1); rom['h21] = ins(17, 'h30);
    rom['h30] = ins(3, 0); rom['h31] = ins(17, 'h20); rom['h32] = ins(0, 0);
    start_prog(0, 2);
    finish_prog("branches");

    // Shift and wrap-around arithmetic results stored to RAM
    clear_mem();
    rom[0] = ins(3, 'h7FF); rom[1] = ins(15, 3);  rom[2] = ins(1, 1);
    rom[3] = ins(3, 1);     rom[4] = ins(14, 15); rom[5] = ins(1, 2);
    rom[6] = ins(3, 'h7FF); rom[7] = ins(5, 1);   rom[8] = ins(1, 3); rom[9] = ins(0, 0);
    start_prog(0, 1);
    finish_prog("shifts");
    chk("sra_result", int'(ram[1]), 'hFFFF);
    chk("sll_result", int'(ram[2]), 'h8000);
    chk("addi_wrap", int'(ram[3]), 0);

    // NOP opcode at the top of the address space, PC wraps to 0
    clear_mem();
    rom[0] = ins(17, 3); rom[1] = ins(3, 1); rom[2] = ins(18, 'h7FF);
    rom['h7FF] = ins(31, 0); rom[3] = ins(0, 0);
    start_prog(0, 0);
    finish_prog("pc_wrap");

    // Reset in the middle of a stalled store
    clear_mem();
    ram[9] = 16'hABCD;
    rom[0] = ins(3, 'h55); rom[1] = ins(1, 9); rom[2] = ins(0, 0);
    waits_q.delete();
    waits_q.push_back(10);
    start_prog(0, 0);
    for (int i = 0; i < 50 && !wr_en; i++) @(negedge clk);
    chk("store_started", int'(wr_en), 1);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("abort_wr_enable", int'(wr_en), 0);
    chk("abort_ram_kept", int'(ram[9]), 'hABCD);
    chk("abort_pc", int'(rom_addr), 0);
    chk("abort_acc", int'(acc), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    finish_prog("reset_abort");

    // Random forward-branching programs
    for (int p = 0; p < 20; p++) begin
      clear_mem();
      waits_q.delete();
      n = 24;
      for (int i = 0; i < n - 1; i++) begin
        op = $urandom_range(31, 1);
        if (op == 1 || op == 2 || op == 4 || op == 6 || op == 8 || op == 10 || op == 12)
          opd = $urandom_range(15, 0);
        else if (op >= 16 && op <= 18)
          opd = $urandom_range(n - 1, i + 1);
        else
          opd = $urandom_range(2047, 0);
        rom[i] = ins(op, opd);
      end
      rom[n - 1] = ins(0, 0);
      start_prog(0, 3);
      finish_prog("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/acc_cpu_core.md
ACC_CPU_CORE -- requirements
Module: acc_cpu_core

Interface
REQ-001 Parameters: NB_INSTRUCTION, default 16, instruction and data width; NB_OPCODE, default 5, opcode field width; NB_OPERAND, default NB_INSTRUCTION-NB_OPCODE, operand field width; NB_ADDR, default 11, ROM/RAM address width (SHALL be <= NB_OPERAND).
REQ-002 i_clock  in  1  single clock, all state on rising edge.
REQ-003 i_reset  in  1  asynchronous, active-low reset.
REQ-004 i_rom_data  in  NB_INSTRUCTION  instruction word, valid 1 cycle after o_rom_addr.
REQ-005 i_ram_data  in  NB_INSTRUCTION  RAM read data, valid in the cycle i_ram_ready=1 during a read.
REQ-006 i_ram_ready  in  1  RAM completes the pending access this cycle.
REQ-007 o_rom_addr  out  NB_ADDR  program counter.
REQ-008 o_ram_addr / o_ram_data  out  NB_ADDR / NB_INSTRUCTION  access address / write data (=ACC).
REQ-009 o_ram_wr_enable / o_ram_rd_enable  out  1 each  access request, held until i_ram_ready.
REQ-010 o_acc  out  NB_INSTRUCTION  accumulator; o_halted  out  1  core stopped.

Function
REQ-011 Instruction = {opcode[NB_OPCODE], operand[NB_OPERAND]}; IMM = operand sign-extended to NB_INSTRUCTION; M = RAM[operand[NB_ADDR-1:0]].
REQ-012 Opcodes: 00 HLT; 01 STO M=ACC; 02 LD ACC=M; 03 LDI ACC=IMM; 04 ADD; 05 ADDI; 06 SUB; 07 SUBI; 08 AND; 09 ANDI; 0A OR; 0B ORI; 0C XOR; 0D XORI (even = M operand, odd = IMM); 0E SLL ACC<<sh; 0F SRA arithmetic ACC>>>sh; 10 BEQ; 11 BNE; 12 JMP; all others NOP.
REQ-013 sh = operand low clog2(NB_INSTRUCTION) bits.
REQ-014 Arithmetic modulo 2^NB_INSTRUCTION, no flags, overflow discarded.
REQ-015 FSM states FETCH, EXEC, MEM, HALT; reset state FETCH.
REQ-016 FETCH: o_rom_addr=PC; next EXEC.
REQ-017 EXEC: decode i_rom_data, latch into IR; non-memory ops update ACC/PC same edge, next FETCH; LD/STO/ADD/SUB/AND/OR/XOR -> MEM; HLT -> HALT, PC unchanged.
REQ-018 MEM: o_ram_addr=IR address, rd_enable (loads/ALU-M) or wr_enable (STO) =1, o_ram_data=ACC; wait while i_ram_ready=0; on i_ram_ready=1 apply op, PC=PC+1, next FETCH.
REQ-019 Enables SHALL be 0 outside MEM and never both 1.
REQ-020 Latency: non-memory 2 cycles; memory 3+W cycles, W = wait cycles with i_ram_ready=0.
REQ-021 PC increment wraps 2^NB_ADDR-1 -> 0.
REQ-022 BEQ: PC=operand[NB_ADDR-1:0] if ACC==0 else PC+1; BNE inverse; JMP unconditional; branch target taken next FETCH.
REQ-023 i_ram_ready=1 outside MEM SHALL be ignored.
REQ-024 HALT: o_halted=1, ACC/PC frozen, no ROM/RAM requests; exit only by reset.

Reset
REQ-025 i_reset=0 asynchronously forces: PC=0, ACC=0, IR=0, state FETCH, o_rom_addr=0, enables=0, o_ram_addr=0, o_ram_data=0, o_halted=0.
REQ-026 Reset asserted during MEM aborts the access; enables drop immediately, no ACC/RAM-visible update.
REQ-027 First fetch of address 0 occurs in the first clock after i_reset returns to 1.

Verification
REQ-028 ROM {LDI 5, ADDI -3, STO 7, HLT}, ready always 1 -> RAM[7]=2, o_acc=2, o_halted=1 after 9 cycles.
REQ-029 LD 4 with i_ram_ready low 3 cycles, RAM[4]=0x1234 -> rd_enable held 4 cycles, o_acc=0x1234, PC advances once.
REQ-030 LDI 0, BEQ 0x20 -> PC=0x20; LDI 1, BNE 0x20 -> PC=0x20; LDI 0, BNE 0x20 -> PC+1.
REQ-031 LDI 0x7FF (=-1), SRA 3 -> 0xFFFF; LDI 1, SLL 15 -> 0x8000; LDI -1, ADDI 1 -> 0x0000.
REQ-032 Opcode 0x1F at PC=0x7FF -> NOP, PC wraps to 0.
REQ-033 Reset mid-MEM STO with ready low -> wr_enable=0 same cycle, RAM unchanged, restart at PC=0.
